uart_sendhs: RTL and testbench
==============================

Name: uart_sendhs

Overview:
- 2 Mbps UART transmitter: 8N1 framing, LSB first, 50 MHz system clock.
- Valid/ready byte input with a small internal FIFO, so upstream logic can burst several bytes without waiting per frame.
- Drives the board TX pin.
- Bit timing (25 clocks/bit) matches the team's 2 Mbps UART receiver, so the two loop back directly.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 2000000, line bit rate in bits/s.
- BPS_CNT, CLK_FREQ/UART_BPS (=25), clocks per bit; localparam, not overridable.
- FIFO_DEPTH, 4, bytes buffered; must be a power of two, minimum 2.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept a byte; registered; equals !fifo_full.
- tx_busy  out  1  FIFO non-empty or frame in progress.
- uart_txd  out  1  serial line; idle high.

Behaviour:
- Reset (async, asserted) values:
  - uart_txd=1, tx_ready=1, tx_busy=0.
  - FIFO pointers and count = 0; FSM = IDLE; bit and clock counters = 0.
- Reset mid-frame: line returns high immediately; FIFO contents are discarded; no partial frame resumes after release.
- Handshake:
  - A byte is accepted on a rising edge where tx_valid && tx_ready.
  - tx_valid while tx_ready=0 is ignored; the producer must hold the byte.
  - tx_data need not be held after acceptance.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of log2(FIFO_DEPTH) bits and a count of log2(FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop on the same edge: count unchanged, both pointers advance. This is legal only when count is nonzero.
  - Full when count==FIFO_DEPTH. tx_ready falls on the edge that makes count full and rises on the edge after a pop from full.
- FSM states: IDLE, START, DATA, STOP; clk_cnt counts 0..BPS_CNT-1.
  - IDLE: uart_txd=1. If FIFO non-empty: pop the head byte into shift register, clk_cnt=0, go to START.
  - START: uart_txd=0 for BPS_CNT clocks, then go to DATA with bit_cnt=0.
  - DATA: uart_txd=shift[0] for BPS_CNT clocks per bit, then shift right.
    - bit_cnt counts 0..7.
    - After bit 7 completes, go to STOP (or PARITY, see Optional Feature).
  - STOP: uart_txd=1 for BPS_CNT clocks.
    - At completion, if FIFO non-empty, pop and go directly to START: zero idle gap, continuous 250-clock frames.
    - Otherwise go to IDLE.
- uart_txd is registered, so it is glitch-free.
- Latency: with FSM idle and FIFO empty, a byte accepted at edge N makes uart_txd fall at edge N+2.
- Frame length is exactly 10*BPS_CNT = 250 clocks.
- tx_busy is registered. It is high from the edge after acceptance until the edge where STOP completes with the FIFO empty.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - State PARITY is inserted between DATA and STOP.
  - The parity bit is even parity, the XOR of the 8 data bits, computed at pop time and held for BPS_CNT clocks.
  - Frame is 11*BPS_CNT = 275 clocks.
- Undefined: no PARITY state and no parity logic; 8N1 framing only.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE/START/DATA/PARITY/STOP).
  - UART_BPS_DEFAULT, CLK_FREQ_DEFAULT.
  - DATA_BITS=8.
- Sub-module uart_tx_fifo:
  - Parameterised synchronous FIFO with push/pop/full/empty/count.
  - Reusable by a later receive-side buffer.
- FSM, counters and shifter stay in uart_sendhs.

Test Plan:
- Single byte: push 0x55 once from idle.
  - Required: uart_txd low at +2 clocks.
  - Then 1,0,1,0,1,0,1,0 each held 25 clocks, stop high 25 clocks.
  - tx_busy drops after 250 clocks.
- Back-to-back: push 0xA5 then 0x3C on consecutive cycles.
  - Required: two frames with no idle gap; second start bit begins on clock 250 after the first start.
  - Receiver loopback returns 0xA5, 0x3C.
- FIFO full: hold tx_valid with 0x01..0x06 while idle.
  - Required: 5 bytes accepted (1 popped immediately, 4 buffered).
  - tx_ready low until the second frame pops; all bytes sent in order, none dropped or duplicated.
- Reset mid-frame: assert sys_rst_n low during DATA bit 3 of 0xF0 with 2 bytes queued.
  - Required: uart_txd=1 asynchronously; after release, line stays idle and tx_busy=0.
- Parity (UART_TX_PARITY_EN defined): send 0x07.
  - Required: parity bit 1 after bit 7; 275-clock frame.
  - With 0x03: parity bit 0.
- Wrap-around: stream 20 bytes with a random-gap valid.
  - Required: pointer wrap exercised; loopback receiver output matches input sequence exactly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, transmitter state encoding and parity helper
package uart_pkg;

    localparam int CLK_FREQ_DEFAULT = 50_000_000;
    localparam int UART_BPS_DEFAULT = 2_000_000;
    localparam int DATA_BITS        = 8;

    // Explicit encodings so the state register value is stable across builds
    // with and without the parity bit.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parameterised circular-buffer FIFO with push/pop/full/empty/count
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset; clears pointers and count
//   push       in   write push_data this edge (ignored when full)
//   push_data  in   WIDTH-bit entry to write
//   pop        in   advance the read pointer this edge (ignored when empty)
//   pop_data   out  entry at the head, valid whenever empty is low
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  number of stored entries, log2(DEPTH)+1 bits
//
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_sendhs.sv
// rtl/uart_sendhs.sv - buffered 8N1 UART transmitter with valid/ready byte input
//
// Ports:
//   sys_clk    in   system clock, rising edge (CLK_FREQ Hz)
//   sys_rst_n  in   asynchronous active-low reset
//   tx_data    in   byte to send
//   tx_valid   in   tx_data valid this cycle; accepted when tx_ready is high
//   tx_ready   out  FIFO can take a byte (registered)
//   tx_busy    out  FIFO non-empty or frame in progress (registered)
//   uart_txd   out  serial line, idle high, LSB first (registered)
//
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit (11-bit frames).
module uart_sendhs
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int UART_BPS   = UART_BPS_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       uart_txd
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CW      = $clog2(BPS_CNT);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int FW      = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CLK_LAST   = CW'(BPS_CNT - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
    localparam logic [FW:0]   CNT_ALMOST = (FW+1)'(FIFO_DEPTH - 1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_STOP   = STOP;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = PARITY;
`endif

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 bit_done;
    logic                 txd_next;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FW:0]          fifo_count;

`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bit_done  = (clk_cnt == CLK_LAST);
    assign fifo_push = tx_valid && tx_ready;

    // The head byte leaves the FIFO either from idle or at the end of a stop
    // bit, the latter chaining frames with no idle gap.
    assign fifo_pop = !fifo_empty &&
                      ((state == S_IDLE) || (state == S_STOP && bit_done));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done && bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    state_next = fifo_empty ? S_IDLE : S_START;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Line level for the state just entered; registering it delays the whole
    // frame by one clock uniformly, which keeps every bit exactly BPS_CNT long.
    always_comb begin
        txd_next = 1'b1;
        case (state)
            S_START:  txd_next = 1'b0;
            S_DATA:   txd_next = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_next = parity_bit;
`endif
            default:  txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state <= state_next;

            if (state == S_IDLE || bit_done) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end

            if (state == S_START && bit_done) begin
                bit_cnt <= '0;
            end else if (state == S_DATA && bit_done) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (fifo_pop) begin
                shift <= fifo_dout;
            end else if (state == S_DATA && bit_done) begin
                shift <= shift >> 1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            parity_bit <= 1'b0;
        end else if (fifo_pop) begin
            parity_bit <= even_parity(fifo_dout);
        end
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            uart_txd <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            uart_txd <= txd_next;
            // Falls on the edge that fills the FIFO; because a full FIFO holds
            // it low through the popping edge, it rises one edge after that.
            tx_ready <= !fifo_full &&
                        !(fifo_count == CNT_ALMOST && fifo_push && !fifo_pop);
            // Uses the occupancy before this edge so busy rises the edge
            // after a byte lands and drops as the last stop bit completes.
            tx_busy  <= (fifo_count != '0) || (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_sendhs.sv
// tb/tb_uart_sendhs.sv - directed and randomized bench for uart_sendhs with loopback receiver model
`timescale 1ns/1ps
module tb_uart_sendhs;

    localparam int BPS = 25;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BPS;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       uart_txd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    logic       rx_en  = 1'b0;
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    int         rx_k   = 0;
    logic [7:0] rx_sh  = 8'h00;

    uart_sendhs dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .uart_txd  (uart_txd)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame slot k: start, 8 data bits LSB first,
    // optional even parity, stop.
    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Loopback receiver: samples mid-bit, half a bit after the falling edge.
    always @(negedge sys_clk) begin
        if (!rx_en) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (uart_txd === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == BPS / 2) begin
                chk("rx_start", uart_txd, 1'b0);
            end else if (rx_cnt > BPS / 2 && (rx_cnt - BPS / 2) % BPS == 0) begin
                rx_k = (rx_cnt - BPS / 2) / BPS;
                if (rx_k <= 8) rx_sh[rx_k-1] = uart_txd;
`ifdef UART_TX_PARITY_EN
                if (rx_k == 9) chk("rx_parity", uart_txd, ^rx_sh);
`endif
                if (rx_k == NBITS - 1) begin
                    chk("rx_stop", uart_txd, 1'b1);
                    rx_q.push_back(rx_sh);
                    rx_act = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    // Offers one byte and holds it until accepted; returns the acceptance edge.
    task automatic send(input logic [7:0] b, output int acc);
        logic r;
        int   n;
        r = 1'b0;
        n = 0;
        acc = -1;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!r && n < 2000) begin
            @(negedge sys_clk);
            r = tx_ready;
            tick();
            n++;
        end
        chk("send_accept", r, 1'b1);
        if (r) begin
            acc = cyc;
            exp_q.push_back(b);
        end
        tx_data = 8'($urandom);
    endtask

    task automatic drain_compare(input string tag);
        int n;
        int m;
        n = 0;
        while ((tx_busy || rx_act) && n < 20000) begin
            tick();
            n++;
        end
        repeat (30) tick();
        chk({tag, "_drained"}, {tx_busy, rx_act}, 2'b00);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    // Sends one byte from idle and checks latency, every slot of the frame
    // and the busy window.
    task automatic check_frame(input logic [7:0] b, input string tag);
        int n;
        send(b, n);
        tx_valid = 1'b0;
        wait_cyc(n + 1);
        chk({tag, "_lat1"}, uart_txd, 1'b1);
        wait_cyc(n + 2);
        chk({tag, "_lat2"}, uart_txd, 1'b0);
        chk({tag, "_busy_on"}, tx_busy, 1'b1);
        for (int k = 0; k < NBITS; k++) begin
            wait_cyc(n + 2 + BPS * k + BPS / 2);
            chk($sformatf("%s_slot%0d", tag, k), uart_txd, fbit(b, k));
        end
        wait_cyc(n + FRAME);
        chk({tag, "_busy_last"}, tx_busy, 1'b1);
        wait_cyc(n + FRAME + 1);
        chk({tag, "_busy_off"}, tx_busy, 1'b0);
    endtask

    initial begin
        int a1, a2, a3, a4, a5, a6;
        int n, d, bad, g;

        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_txd", uart_txd, 1'b1);
        chk("reset_ready", tx_ready, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);
        #4 sys_rst_n = 1'b1;
        tick();
        rx_en = 1'b1;
        repeat (5) tick();
        chk("idle_txd", uart_txd, 1'b1);

        // Single byte from idle.
        check_frame(8'h55, "single");
        drain_compare("single");

        // Two random frames for a wider spread of data patterns.
        check_frame(8'($urandom), "rand0");
        check_frame(8'($urandom), "rand1");
        drain_compare("rand");

        // Back-to-back bytes: second start bit exactly one frame after the first.
        send(8'hA5, a1);
        send(8'h3C, a2);
        tx_valid = 1'b0;
        chk("b2b_consecutive", a2 - a1, 1);
        wait_cyc(a1 + FRAME + 1);
        chk("b2b_stop_end", uart_txd, 1'b1);
        wait_cyc(a1 + FRAME + 2);
        chk("b2b_start2", uart_txd, 1'b0);
        drain_compare("b2b");

        // FIFO fill: five accepted back to back, sixth held until the second pop.
        send(8'h01, a1);
        send(8'h02, a2);
        send(8'h03, a3);
        send(8'h04, a4);
        send(8'h05, a5);
        chk("full_burst", a5 - a1, 4);
        chk("full_ready_low", tx_ready, 1'b0);
        send(8'h06, a6);
        tx_valid = 1'b0;
        chk("full_resume_not_early", a6 >= a1 + FRAME + 2, 1'b1);
        chk("full_resume_not_late", a6 <= a1 + FRAME + 3, 1'b1);
        drain_compare("full");

        // Reset during data bit 3 of 0xF0 with two bytes queued.
        send(8'hF0, n);
        send(8'h11, d);
        send(8'h22, d);
        tx_valid = 1'b0;
        wait_cyc(n + 2 + BPS * 4 + BPS / 2);
        chk("rst_pre_bit3", uart_txd, 1'b0);
        #3;
        rx_en = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        chk("rst_async_txd", uart_txd, 1'b1);
        chk("rst_async_busy", tx_busy, 1'b0);
        chk("rst_async_ready", tx_ready, 1'b1);
        repeat (3) @(posedge sys_clk);
        #5 sys_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("rst_line_stays_idle", bad, 0);
        exp_q.delete();
        rx_q.delete();
        rx_en = 1'b1;

`ifdef UART_TX_PARITY_EN
        check_frame(8'h07, "par07");
        check_frame(8'h03, "par03");
        drain_compare("parity");
`endif

        // Random-gap stream long enough to wrap the FIFO pointers many times.
        for (int i = 0; i < 20; i++) begin
            g = $urandom_range(0, 3);
            if (g != 0) begin
                tx_valid = 1'b0;
                repeat (g) tick();
            end
            send(8'($urandom), d);
        end
        tx_valid = 1'b0;
        drain_compare("stream");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
